// File: rtl/saw_pkg.sv
// Shared definitions for the stop-and-wait ARQ link, used by both the transmit-side
// CRC generator/FSM and the receive-side checker.
package saw_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCheck,
      StDeliver,
      StResp
   } saw_state_e;

   localparam int unsigned BW_DEF = 10;
   localparam int unsigned CRC_W_DEF = 3;
   localparam logic [CRC_W_DEF:0] POLY_DEF = 4'b1011;

   // Frame layout: {seq, payload, crc}
   function automatic int unsigned seq_bit(input int unsigned bw);
      return bw - 1;
   endfunction

   function automatic int unsigned pay_hi(input int unsigned bw);
      return bw - 2;
   endfunction

   function automatic int unsigned pay_lo(input int unsigned crc_w);
      return crc_w;
   endfunction

endpackage

// File: rtl/crc_serial_chk.sv
// Serial CRC divider: one frame bit per enabled cycle, MSB first. The remainder is zero
// exactly when the shifted-in bit string is a multiple of the generator polynomial.
module crc_serial_chk #(
   parameter int unsigned    CRC_W = 3,
   parameter logic [CRC_W:0] POLY  = 4'b1011
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             shift_en_i,
   input  logic             bit_in_i,
   output logic [CRC_W-1:0] rem_o
);

   logic [CRC_W-1:0] rem_d, rem_q;

   always_comb begin
      rem_d = rem_q;
      if (clear_i) begin
         rem_d = '0;
      end else if (shift_en_i) begin
         // The x^CRC_W term shifted out is folded back in as the generator's low terms
         rem_d = {rem_q[CRC_W-2:0], bit_in_i} ^ (rem_q[CRC_W-1] ? POLY[CRC_W-1:0] : '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign rem_o = rem_q;

endmodule

// File: rtl/saw_rx_checker.sv
// Receive-side checker for the stop-and-wait ARQ link: serial CRC check, duplicate
// filtering by sequence bit, payload delivery and ACK/NAK return to the sender.
module saw_rx_checker
   import saw_pkg::*;
#(
   parameter int unsigned    BW    = BW_DEF,
   parameter int unsigned    CRC_W = CRC_W_DEF,
   parameter logic [CRC_W:0] POLY  = POLY_DEF,
   parameter int unsigned    CNT_W = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                frame_valid,
   input  logic [BW-1:0]       frame,
   output logic                frame_ready,
   output logic                data_valid,
   output logic [BW-2-CRC_W:0] data,
   input  logic                data_ready,
   output logic                ack_valid,
   output logic                ack_seq,
   output logic                ack_nak,
   input  logic                ack_ready,
   output logic [CNT_W-1:0]    err_cnt,
   output logic [CNT_W-1:0]    dup_cnt
);

   localparam int unsigned SEQ   = seq_bit(BW);
   localparam int unsigned P_HI  = pay_hi(BW);
   localparam int unsigned P_LO  = pay_lo(CRC_W);
   // One extra bit so the count can run below zero, marking the decision cycle
   localparam int unsigned IDX_W = $clog2(BW) + 1;

   saw_state_e          state_d, state_q;
   logic [BW-1:0]       frame_d, frame_q;
   logic [IDX_W-1:0]    cnt_d, cnt_q;
   logic                exp_seq_d, exp_seq_q;
   logic [BW-2-CRC_W:0] data_d, data_q;
   logic                data_valid_d, data_valid_q;
   logic                ack_valid_d, ack_valid_q;
   logic                ack_seq_d, ack_seq_q;
   logic                ack_nak_d, ack_nak_q;
   logic [CNT_W-1:0]    err_cnt_d, err_cnt_q;
   logic [CNT_W-1:0]    dup_cnt_d, dup_cnt_q;

   logic             crc_clear, crc_shift;
   logic [CRC_W-1:0] crc_rem;

   crc_serial_chk #(
      .CRC_W (CRC_W),
      .POLY  (POLY)
   ) u_crc (
      .clk_i      (clk),
      .rst_i      (rstn),
      .clear_i    (crc_clear),
      .shift_en_i (crc_shift),
      .bit_in_i   (frame_q[cnt_q[IDX_W-2:0]]),
      .rem_o      (crc_rem)
   );

   always_comb begin
      state_d      = state_q;
      frame_d      = frame_q;
      cnt_d        = cnt_q;
      exp_seq_d    = exp_seq_q;
      data_d       = data_q;
      data_valid_d = data_valid_q;
      ack_valid_d  = ack_valid_q;
      ack_seq_d    = ack_seq_q;
      ack_nak_d    = ack_nak_q;
      err_cnt_d    = err_cnt_q;
      dup_cnt_d    = dup_cnt_q;
      crc_clear    = 1'b0;
      crc_shift    = 1'b0;

      case (state_q)
         StIdle: begin
            if (frame_valid) begin
               frame_d   = frame;
               cnt_d     = IDX_W'(BW - 1);
               crc_clear = 1'b1;
               state_d   = StCheck;
            end
         end
         StCheck: begin
            if (!cnt_q[IDX_W-1]) begin
               crc_shift = 1'b1;
               cnt_d     = cnt_q - IDX_W'(1);
            end else if (crc_rem != '0) begin
               ack_valid_d = 1'b1;
               ack_seq_d   = exp_seq_q;
               ack_nak_d   = 1'b1;
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
               state_d     = StResp;
            end else if (frame_q[SEQ] == exp_seq_q) begin
               data_d       = frame_q[P_HI:P_LO];
               data_valid_d = 1'b1;
               state_d      = StDeliver;
            end else begin
               ack_valid_d = 1'b1;
               ack_seq_d   = frame_q[SEQ];
               ack_nak_d   = 1'b0;
               if (dup_cnt_q != '1) dup_cnt_d = dup_cnt_q + CNT_W'(1);
               state_d     = StResp;
            end
         end
         StDeliver: begin
            if (data_ready) begin
               data_valid_d = 1'b0;
               ack_valid_d  = 1'b1;
               ack_seq_d    = frame_q[SEQ];
               ack_nak_d    = 1'b0;
               exp_seq_d    = ~exp_seq_q;
               state_d      = StResp;
            end
         end
         StResp: begin
            if (ack_ready) begin
               ack_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q      <= StIdle;
         frame_q      <= '0;
         cnt_q        <= '0;
         exp_seq_q    <= 1'b0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         ack_valid_q  <= 1'b0;
         ack_seq_q    <= 1'b0;
         ack_nak_q    <= 1'b0;
         err_cnt_q    <= '0;
         dup_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         frame_q      <= frame_d;
         cnt_q        <= cnt_d;
         exp_seq_q    <= exp_seq_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         ack_valid_q  <= ack_valid_d;
         ack_seq_q    <= ack_seq_d;
         ack_nak_q    <= ack_nak_d;
         err_cnt_q    <= err_cnt_d;
         dup_cnt_q    <= dup_cnt_d;
      end
   end

   assign frame_ready = (state_q == StIdle) && !rstn;
   assign data_valid  = data_valid_q;
   assign data        = data_q;
   assign ack_valid   = ack_valid_q;
   assign ack_seq     = ack_seq_q;
   assign ack_nak     = ack_nak_q;
   assign err_cnt     = err_cnt_q;
   assign dup_cnt     = dup_cnt_q;

endmodule
